// File: rtl/led_pkg.sv
// Shared widths, frame-buffer types and controller state encoding for the
// LED matrix frame controller.
package led_pkg;

    localparam int LED_COLS  = 4;
    localparam int LED_COL_W = 2;
    localparam int LED_ROW_W = 8;
    localparam int LED_PWM_W = 3;

    typedef logic [LED_ROW_W-1:0] led_col_t;
    typedef led_col_t [LED_COLS-1:0] led_frame_t;

    typedef enum logic {
        ST_ACCEPT    = 1'b0,
        ST_SWAP_WAIT = 1'b1
    } frame_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant searched from the slot after the last
// granted requester; the pointer moves only when the grant is consumed.
module rr_arbiter #(
    parameter int N = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] grant
);

    localparam int PTR_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [PTR_W-1:0] PTR_RESET = PTR_W'(N - 1);

    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [PTR_W-1:0] gnt_idx;
    logic             found;
    int unsigned      idx;

    always_comb begin
        grant   = '0;
        found   = 1'b0;
        gnt_idx = ptr_q;
        idx     = 0;
        for (int k = 1; k <= N; k++) begin
            idx = (int'(ptr_q) + k) % N;
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
                gnt_idx    = PTR_W'(idx);
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (advance && found) begin
            ptr_d = gnt_idx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= PTR_RESET;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/led_frame_ctrl.sv
// Double-buffered LED frame controller: arbitrated column writes land in the
// back buffer, which is copied to the display buffer only at a frame boundary.
module led_frame_ctrl
    import led_pkg::*;
#(
    parameter int NUM_REQ      = 2,
    parameter int FRAME_CYCLES = 12000,
    parameter int BRIGHT_RESET = 7
) (
    input  logic                   clk12MHz,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [2*NUM_REQ-1:0]   req_col,
    input  logic [8*NUM_REQ-1:0]   req_data,
    input  logic [NUM_REQ-1:0]     req_commit,
    input  logic                   bright_we,
    input  logic [LED_PWM_W-1:0]   bright_in,
    output logic [LED_ROW_W-1:0]   leds1,
    output logic [LED_ROW_W-1:0]   leds2,
    output logic [LED_ROW_W-1:0]   leds3,
    output logic [LED_ROW_W-1:0]   leds4,
    output logic [LED_PWM_W-1:0]   leds_pwm,
    output logic                   frame_tick,
    output logic                   swap_pending
);

    localparam int CNT_W = (FRAME_CYCLES > 2) ? $clog2(FRAME_CYCLES) : 1;
    localparam logic [CNT_W-1:0]     CNT_MAX   = CNT_W'(FRAME_CYCLES - 1);
    localparam logic [LED_PWM_W-1:0] PWM_RESET = LED_PWM_W'(BRIGHT_RESET);

    frame_state_e           state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    led_frame_t             front_q, front_d;
    led_frame_t             back_q, back_d;
    logic [LED_PWM_W-1:0]   shadow_q, shadow_d;
    logic [LED_PWM_W-1:0]   pwm_q, pwm_d;
    logic                   pending_q, pending_d;

    logic [NUM_REQ-1:0]     arb_req;
    logic [NUM_REQ-1:0]     grant;
    logic                   xfer;
    logic [LED_COL_W-1:0]   sel_col;
    led_col_t               sel_data;
    logic                   sel_commit;

    // Requests are masked while a committed frame waits, so the arbiter
    // neither grants nor moves its pointer during SWAP_WAIT.
    assign arb_req = (state_q == ST_ACCEPT) ? req_valid : '0;

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .clk     (clk12MHz),
        .rst_n   (rst_n),
        .req     (arb_req),
        .advance (xfer),
        .grant   (grant)
    );

    assign req_ready  = grant;
    assign xfer       = |grant;
    assign frame_tick = (cnt_q == CNT_MAX);

    always_comb begin
        sel_col    = '0;
        sel_data   = '0;
        sel_commit = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_col    = req_col[2*i +: 2];
                sel_data   = req_data[8*i +: 8];
                sel_commit = req_commit[i];
            end
        end
    end

    always_comb begin
        cnt_d     = frame_tick ? '0 : cnt_q + 1'b1;
        back_d    = back_q;
        front_d   = front_q;
        state_d   = state_q;
        shadow_d  = bright_we ? bright_in : shadow_q;
        pwm_d     = frame_tick ? shadow_q : pwm_q;
        if (xfer) begin
            back_d[sel_col] = sel_data;
        end
        case (state_q)
            ST_ACCEPT: begin
                // A commit landing on the tick cycle waits for the next tick.
                if (xfer && sel_commit) begin
                    state_d = ST_SWAP_WAIT;
                end
            end
            ST_SWAP_WAIT: begin
                if (frame_tick) begin
                    front_d = back_q;
                    state_d = ST_ACCEPT;
                end
            end
            default: state_d = ST_ACCEPT;
        endcase
        pending_d = (state_d == ST_SWAP_WAIT);
    end

    always_ff @(posedge clk12MHz or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_ACCEPT;
            cnt_q     <= '0;
            front_q   <= '0;
            back_q    <= '0;
            shadow_q  <= PWM_RESET;
            pwm_q     <= PWM_RESET;
            pending_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            front_q   <= front_d;
            back_q    <= back_d;
            shadow_q  <= shadow_d;
            pwm_q     <= pwm_d;
            pending_q <= pending_d;
        end
    end

    assign leds1        = front_q[0];
    assign leds2        = front_q[1];
    assign leds3        = front_q[2];
    assign leds4        = front_q[3];
    assign leds_pwm     = pwm_q;
    assign swap_pending = pending_q;

endmodule

// File: tb/tb_led_frame_ctrl.sv
// Directed bench for led_frame_ctrl with a 16-cycle frame and two requesters;
// expected values are hand-computed per scenario.
module tb_led_frame_ctrl;

    localparam int NUM_REQ      = 2;
    localparam int FRAME_CYCLES = 16;

    logic         clk12MHz;
    logic         rst_n;
    logic [1:0]   req_valid;
    logic [1:0]   req_ready;
    logic [3:0]   req_col;
    logic [15:0]  req_data;
    logic [1:0]   req_commit;
    logic         bright_we;
    logic [2:0]   bright_in;
    logic [7:0]   leds1, leds2, leds3, leds4;
    logic [2:0]   leds_pwm;
    logic         frame_tick;
    logic         swap_pending;

    int checks = 0;
    int errors = 0;
    int exp_cnt = 0;
    int ticks_seen;

    led_frame_ctrl #(
        .NUM_REQ      (NUM_REQ),
        .FRAME_CYCLES (FRAME_CYCLES),
        .BRIGHT_RESET (7)
    ) dut (
        .clk12MHz     (clk12MHz),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_col      (req_col),
        .req_data     (req_data),
        .req_commit   (req_commit),
        .bright_we    (bright_we),
        .bright_in    (bright_in),
        .leds1        (leds1),
        .leds2        (leds2),
        .leds3        (leds3),
        .leds4        (leds4),
        .leds_pwm     (leds_pwm),
        .frame_tick   (frame_tick),
        .swap_pending (swap_pending)
    );

    // Clock and reference frame-position counter.
    initial clk12MHz = 1'b0;
    always #5 clk12MHz = ~clk12MHz;

    always @(posedge clk12MHz or negedge rst_n) begin
        if (!rst_n) exp_cnt <= 0;
        else        exp_cnt <= (exp_cnt == FRAME_CYCLES - 1) ? 0 : exp_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_cnt(input int v);
        int n = 0;
        while (exp_cnt != v && n < 40) begin
            @(negedge clk12MHz);
            n++;
        end
        if (exp_cnt != v) check("wait_cnt_timeout", exp_cnt, v);
    endtask

    task automatic drive(input logic [1:0] v, input logic [1:0] c1, input logic [7:0] d1,
                         input logic cm1, input logic [1:0] c0, input logic [7:0] d0,
                         input logic cm0);
        req_valid  = v;
        req_col    = {c1, c0};
        req_data   = {d1, d0};
        req_commit = {cm1, cm0};
    endtask

    task automatic idle();
        drive(2'b00, 2'd0, 8'h00, 1'b0, 2'd0, 8'h00, 1'b0);
    endtask

    initial begin
        rst_n     = 1'b0;
        bright_we = 1'b0;
        bright_in = 3'd0;
        idle();
        repeat (3) @(negedge clk12MHz);

        // Reset values.
        check("rst_leds1", leds1, 8'h00);
        check("rst_leds4", leds4, 8'h00);
        check("rst_pwm", leds_pwm, 3'd7);
        check("rst_pending", swap_pending, 1'b0);
        check("rst_tick", frame_tick, 1'b0);
        rst_n = 1'b1;

        // Round robin: both valid, grants 0,1,0,1; req1 commits on its second grant.
        wait_cnt(1);
        drive(2'b11, 2'd1, 8'h22, 1'b0, 2'd0, 8'h11, 1'b0);
        #1 check("rr_grant0", req_ready, 2'b01);
        @(negedge clk12MHz);
        #1 check("rr_grant1", req_ready, 2'b10);
        @(negedge clk12MHz);
        drive(2'b11, 2'd1, 8'h22, 1'b1, 2'd0, 8'h11, 1'b0);
        #1 check("rr_grant2", req_ready, 2'b01);
        @(negedge clk12MHz);
        #1 check("rr_grant3", req_ready, 2'b10);
        @(negedge clk12MHz);
        idle();
        #1 check("rr_pending", swap_pending, 1'b1);
        check("rr_pre_leds2", leds2, 8'h00);
        wait_cnt(15);
        @(negedge clk12MHz);
        #1 check("rr_leds1", leds1, 8'h11);
        check("rr_leds2", leds2, 8'h22);
        check("rr_leds3", leds3, 8'h00);
        check("rr_done", swap_pending, 1'b0);

        // Single write without commit never reaches the display.
        wait_cnt(2);
        drive(2'b01, 2'd0, 8'h00, 1'b0, 2'd2, 8'hA5, 1'b0);
        #1 check("single_ready", req_ready, 2'b01);
        @(negedge clk12MHz);
        idle();
        ticks_seen = 0;
        repeat (40) begin
            @(negedge clk12MHz);
            if (frame_tick) ticks_seen++;
        end
        check("single_ticks", ticks_seen, 2);
        check("single_leds3", leds3, 8'h00);
        check("single_pending", swap_pending, 1'b0);

        // Commit flow: col0 then col3 with commit; swap at next tick.
        wait_cnt(3);
        drive(2'b01, 2'd0, 8'h00, 1'b0, 2'd0, 8'h01, 1'b0);
        #1 check("cm_ready0", req_ready, 2'b01);
        @(negedge clk12MHz);
        drive(2'b01, 2'd0, 8'h00, 1'b0, 2'd3, 8'h80, 1'b1);
        #1 check("cm_ready1", req_ready, 2'b01);
        @(negedge clk12MHz);
        drive(2'b11, 2'd0, 8'h00, 1'b0, 2'd1, 8'h77, 1'b0);
        #1 check("cm_pending", swap_pending, 1'b1);
        check("cm_ready_blocked", req_ready, 2'b00);
        @(negedge clk12MHz);
        idle();
        wait_cnt(15);
        #1 check("cm_tick", frame_tick, 1'b1);
        check("cm_old_leds1", leds1, 8'h11);
        @(negedge clk12MHz);
        #1 check("cm_leds1", leds1, 8'h01);
        check("cm_leds2", leds2, 8'h22);
        check("cm_leds3", leds3, 8'hA5);
        check("cm_leds4", leds4, 8'h80);
        check("cm_done", swap_pending, 1'b0);

        // Commit transferred on the tick cycle: swap one full frame later.
        wait_cnt(15);
        drive(2'b01, 2'd0, 8'h00, 1'b0, 2'd1, 8'h44, 1'b1);
        #1 check("ot_ready", req_ready, 2'b01);
        check("ot_tick", frame_tick, 1'b1);
        @(negedge clk12MHz);
        idle();
        #1 check("ot_no_swap", leds2, 8'h22);
        check("ot_pending", swap_pending, 1'b1);
        wait_cnt(15);
        #1 check("ot_still_old", leds2, 8'h22);
        @(negedge clk12MHz);
        #1 check("ot_leds2", leds2, 8'h44);
        check("ot_done", swap_pending, 1'b0);

        // Brightness updates only at tick edges.
        wait_cnt(5);
        bright_we = 1'b1;
        bright_in = 3'd3;
        @(negedge clk12MHz);
        bright_we = 1'b0;
        #1 check("br_hold", leds_pwm, 3'd7);
        wait_cnt(15);
        #1 check("br_before_tick", leds_pwm, 3'd7);
        @(negedge clk12MHz);
        #1 check("br_applied", leds_pwm, 3'd3);
        wait_cnt(15);
        bright_we = 1'b1;
        bright_in = 3'd1;
        @(negedge clk12MHz);
        bright_we = 1'b0;
        #1 check("br_late_hold", leds_pwm, 3'd3);
        wait_cnt(15);
        @(negedge clk12MHz);
        #1 check("br_late_applied", leds_pwm, 3'd1);

        // Async reset in SWAP_WAIT discards the pending frame.
        wait_cnt(4);
        drive(2'b01, 2'd0, 8'h00, 1'b0, 2'd0, 8'h55, 1'b1);
        @(negedge clk12MHz);
        idle();
        #1 check("ar_pending", swap_pending, 1'b1);
        wait_cnt(8);
        #2 rst_n = 1'b0;
        #1 check("ar_leds1", leds1, 8'h00);
        check("ar_leds2", leds2, 8'h00);
        check("ar_leds4", leds4, 8'h00);
        check("ar_pwm", leds_pwm, 3'd7);
        check("ar_pending_clr", swap_pending, 1'b0);
        repeat (2) @(negedge clk12MHz);
        rst_n = 1'b1;
        drive(2'b01, 2'd0, 8'h00, 1'b0, 2'd0, 8'h66, 1'b0);
        #1 check("ar_ready", req_ready, 2'b01);
        @(negedge clk12MHz);
        idle();
        repeat (40) @(negedge clk12MHz);
        check("ar_no_swap", leds1, 8'h00);
        check("ar_idle", swap_pending, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/led_frame_ctrl.md
Name: led_frame_ctrl

Overview:
- Scheduler and arbiter for the shared 4-column x 8-row LED matrix frame buffer that feeds LedDisplay (leds1..leds4, leds_pwm).
- Accepts column writes from NUM_REQ requesters via valid/ready with round-robin arbitration into a back buffer.
- Presents the front buffer to the display, swapping back->front only at a frame boundary, so no partial frame is ever shown.
- Also owns the display brightness (leds_pwm), which is likewise updated only at frame boundaries.

Parameters:
- NUM_REQ, 2: number of requesters; legal range 1..4.
- FRAME_CYCLES, 12000: clk12MHz cycles per frame period (1 ms); legal range >= 2.
- BRIGHT_RESET, 7: leds_pwm value after reset.

Ports:
- clk12MHz  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester write request.
- req_ready  out  NUM_REQ  per-requester accept; transfer occurs when valid & ready.
- req_col  in  2*NUM_REQ  column index 0..3 per requester; slice i = [2i+1:2i].
- req_data  in  8*NUM_REQ  row bits per requester; slice i = [8i+7:8i].
- req_commit  in  NUM_REQ  qualified by a transfer: this write ends the requester's frame; request a swap.
- bright_we  in  1  load brightness shadow register.
- bright_in  in  3  new brightness value.
- leds1, leds2, leds3, leds4  out  8 each  front-buffer columns 0..3, to LedDisplay.
- leds_pwm  out  3  active brightness, to LedDisplay.
- frame_tick  out  1  one-cycle pulse at the end of each frame.
- swap_pending  out  1  high while a committed frame waits for frame_tick.

Behaviour:
- Reset (async assert, sync release):
  - front = back = 0, so leds1..4 = 0.
  - leds_pwm = shadow = BRIGHT_RESET.
  - frame counter = 0; frame_tick = 0; swap_pending = 0.
  - state = ACCEPT; rr pointer = NUM_REQ-1, so req 0 has top priority first.
- Frame counter:
  - Counts 0..FRAME_CYCLES-1, then wraps to 0.
  - frame_tick = 1 combinationally while counter == FRAME_CYCLES-1.
  - Runs freely in both states.
- State ACCEPT:
  - grant = first i with req_valid[i], searched from ptr+1 upward modulo NUM_REQ.
  - req_ready[i] = req_valid[i] && (i == grant); all other ready bits are 0. At most one transfer per cycle.
  - On transfer: back[req_col] <= req_data; ptr <= grant.
  - If req_commit[grant] is also set: state -> SWAP_WAIT.
- State SWAP_WAIT:
  - All req_ready = 0; swap_pending = 1.
  - On a clock edge with frame_tick = 1: front <= back (all four columns atomically); state -> ACCEPT.
  - The back buffer is retained after the swap, so later frames may be partial updates.
- Latency:
  - A write is visible on the leds outputs on the cycle after the swapping frame_tick edge.
  - Minimum 1 cycle after the commit; maximum FRAME_CYCLES cycles.
- Commit transfer in the same cycle as frame_tick: the write lands in back and the state enters SWAP_WAIT. The swap happens at the NEXT frame_tick, not the current one.
- Brightness:
  - bright_we loads shadow on the next edge.
  - On every frame_tick edge, leds_pwm <= shadow (the pre-edge value). A write coinciding with the tick takes effect at the following tick.
- Two writes to the same column before a swap: last write wins.
- Requesters must hold valid, col, data and commit stable until ready. Dropping valid without a transfer is legal and has no effect.
- Reset asserted mid-SWAP_WAIT: the pending frame is discarded; all state returns to reset values.
- NUM_REQ = 1: the arbiter degenerates to ready = valid in ACCEPT.

Decomposition:
- Shared package led_pkg:
  - LED_COLS = 4, LED_COL_W = 2, LED_ROW_W = 8, LED_PWM_W = 3.
  - Typedef led_col_t (8 bits) and led_frame_t (array of 4 led_col_t).
- One sub-module, rr_arbiter (parameter N):
  - Inputs: req, advance.
  - Outputs: one-hot grant.
  - Internal last-grant pointer; resets to N-1.
- FSM, frame counter, buffers and brightness logic stay in led_frame_ctrl.

Test Plan (FRAME_CYCLES=16, NUM_REQ=2):
- Single write, no commit: req0 writes col 2 = 8'hA5 -> req_ready[0] = 1 that cycle; leds3 stays 0 across several frame_ticks.
- Commit flow: req0 writes col0 = 8'h01 (no commit), then col3 = 8'h80 with commit -> swap_pending = 1 and ready = 0 until the next frame_tick; the next cycle leds1 = 8'h01, leds4 = 8'h80, swap_pending = 0.
- Round robin: both requesters hold valid with no commit -> grants alternate 0,1,0,1 starting with 0; each writes a distinct column; back holds both values after the swap.
- Commit on the tick cycle: commit transfer exactly when counter = 15 -> no swap at that edge; swap at the following tick, 16 cycles later.
- Brightness: bright_we with bright_in = 3 at counter = 5 -> leds_pwm stays 7 until the tick edge, then 3. A write of 1 at counter = 15 -> applied one frame later.
- Async reset during SWAP_WAIT: deassert rst_n mid-cycle -> leds1..4 = 0, leds_pwm = 7, ready restored after release, and the pending swap never occurs.
